// File: rtl/pic_pkg.sv
// Shared types and helpers for the 8259A-style interrupt controller blocks.
package pic_pkg;

  localparam int unsigned Levels = 8;
  localparam int unsigned LevelW = 3;
  localparam int unsigned BaseW  = 5;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StAck1,
    StWait2,
    StAck2
  } ack_state_e;

  // Binary index of a one-hot vector; returns the highest set bit if several are set.
  function automatic logic [LevelW-1:0] onehot_encode(input logic [Levels-1:0] v);
    logic [LevelW-1:0] idx;
    idx = '0;
    for (int i = 0; i < Levels; i++) begin
      if (v[i]) idx = LevelW'(i);
    end
    return idx;
  endfunction

  function automatic logic [7:0] rotate_left8(input logic [7:0] v, input logic [2:0] n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

endpackage

// File: rtl/rotating_priority_select.sv
// Picks the highest-priority set bit of isr_i, where priority starts at the level
// just after the one-hot rotation pointer and wraps 7 -> 0.
module rotating_priority_select
  import pic_pkg::*;
(
  input  logic [7:0] isr_i,
  input  logic [7:0] pointer_i,
  output logic [7:0] highest_o
);

  logic [2:0] start;
  logic [7:0] rot;
  logic [7:0] low;

  always_comb begin
    start     = onehot_encode(pointer_i) + 3'd1;
    // Rotate so the highest-priority level lands on bit 0, isolate the lowest set bit,
    // then rotate back into place.
    rot       = rotate_left8(isr_i, 3'd0 - start);
    low       = rot & (~rot + 8'd1);
    highest_o = rotate_left8(low, start);
  end

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// Runs the INT / two-pulse INTA handshake, maintains the in-service register and
// applies normal, specific and automatic EOI with optional priority rotation.
module interrupt_ack_sequencer
  import pic_pkg::*;
#(
  parameter int unsigned LEVELS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LEVELS-1:0] interrupt,
  input  logic              inta_n,
  input  logic [4:0]        vector_base,
  input  logic              auto_eoi,
  input  logic              rotate_on_aeoi,
  input  logic              eoi_valid,
  input  logic              eoi_specific,
  input  logic [2:0]        eoi_level,
  input  logic              eoi_rotate,
  output logic              int_out,
  output logic [LEVELS-1:0] in_service_register,
  output logic [LEVELS-1:0] highest_level_in_service,
  output logic [LEVELS-1:0] clear_irr,
  output logic [7:0]        data_out,
  output logic              data_oe
);

  ack_state_e  state_q, state_d;
  logic        inta_q, inta_prev_q;
  logic [2:0]  level_q, level_d;
  logic        spurious_q, spurious_d;
  logic [7:0]  isr_q, isr_d;
  logic [7:0]  pointer_q, pointer_d;
  logic [7:0]  clear_irr_q, clear_irr_d;

  logic        fall, rise;
  logic [7:0]  ack_set, aeoi_clear, eoi_highest, eoi_target, eoi_clear;
  logic        aeoi_rotate;

  assign fall = inta_prev_q & ~inta_q;
  assign rise = ~inta_prev_q & inta_q;

  rotating_priority_select u_eoi_select (
    .isr_i    (isr_q),
    .pointer_i(pointer_q),
    .highest_o(eoi_highest)
  );

  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    spurious_d  = spurious_q;
    ack_set     = '0;
    aeoi_clear  = '0;
    aeoi_rotate = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (interrupt != '0) state_d = StReq;
      end
      StReq: begin
        if (fall) begin
          state_d = StAck1;
          if (interrupt != '0) begin
            level_d    = onehot_encode(interrupt);
            spurious_d = 1'b0;
            ack_set    = 8'd1 << onehot_encode(interrupt);
          end else begin
            // Request vanished before the acknowledge: answer with IR7, touch nothing.
            level_d    = 3'd7;
            spurious_d = 1'b1;
          end
        end
      end
      StAck1: begin
        if (rise) state_d = StWait2;
      end
      StWait2: begin
        if (fall) state_d = StAck2;
      end
      StAck2: begin
        if (rise) begin
          state_d = StIdle;
          if (auto_eoi && !spurious_q) begin
            aeoi_clear  = 8'd1 << level_q;
            aeoi_rotate = rotate_on_aeoi;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    clear_irr_d = ack_set;
    eoi_target  = eoi_specific ? (8'd1 << eoi_level) : eoi_highest;
    eoi_clear   = eoi_valid ? (eoi_target & isr_q) : '0;
    // A set from the acknowledge wins over any clear of the same bit.
    isr_d       = (isr_q & ~eoi_clear & ~aeoi_clear) | ack_set;
    pointer_d   = pointer_q;
    if (aeoi_rotate) pointer_d = 8'd1 << level_q;
    if (eoi_valid && eoi_rotate && (eoi_clear != '0)) pointer_d = eoi_clear;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      inta_q      <= 1'b1;
      inta_prev_q <= 1'b1;
      level_q     <= '0;
      spurious_q  <= 1'b0;
      isr_q       <= '0;
      pointer_q   <= 8'b1000_0000;
      clear_irr_q <= '0;
    end else begin
      state_q     <= state_d;
      inta_q      <= inta_n;
      inta_prev_q <= inta_q;
      level_q     <= level_d;
      spurious_q  <= spurious_d;
      isr_q       <= isr_d;
      pointer_q   <= pointer_d;
      clear_irr_q <= clear_irr_d;
    end
  end

  assign int_out                  = (state_q == StReq);
  assign data_oe                  = (state_q == StAck2);
  assign data_out                 = data_oe ? {vector_base, level_q} : '0;
  assign in_service_register      = isr_q;
  assign highest_level_in_service = pointer_q;
  assign clear_irr                = clear_irr_q;

endmodule
